// File: rtl/param_dm_cache_if.sv
// Bus bundle between the pipeline port, the cache and the RAM path.
// The cache connects through the slave modport; the pipeline/RAM side uses master.
interface param_dm_cache_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  // cpu_req is sampled only while the cache is idle and completes with a one-cycle
  // cpu_ready pulse; mem_req and its we/addr/wdata are held stable until the edge
  // that samples mem_ack, and mem_ack is ignored while mem_req is low.
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/param_dm_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with one-word lines,
// flush, busy flag and saturating hit/miss counters.
module param_dm_cache #(
  parameter int AW    = 8,
  parameter int DW    = 32,
  parameter int LINES = 16,
  parameter int CW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  param_dm_cache_if.slave     bus,
  output logic                busy,
  output logic [CW-1:0]       hit_cnt,
  output logic [CW-1:0]       miss_cnt,
  output logic [1:0]          dbg_state
);
  localparam int IW = $clog2(LINES);
  localparam int TW = AW - IW;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOOKUP  = 2'd1,
    S_MISS_RD = 2'd2,
    S_WR_THRU = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TW-1:0]   tag_q  [LINES];
  logic [TW-1:0]   tag_d  [LINES];
  logic [DW-1:0]   data_q [LINES];
  logic [DW-1:0]   data_d [LINES];
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            flush_pend_q, flush_pend_d;
  logic [CW-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CW-1:0]   miss_cnt_q, miss_cnt_d;

  logic [IW-1:0]   idx;
  logic [TW-1:0]   tag;
  logic            hit;

  assign idx = addr_q[IW-1:0];
  assign tag = addr_q[AW-1:IW];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + {{(CW-1){1'b0}}, 1'b1};
  endfunction

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      flush_pend_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      flush_pend_q <= flush_pend_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
    end
  end

  // Next-state and array/counter updates.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    flush_pend_d = flush_pend_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    case (state_q)
      S_IDLE: begin
        // A live or deferred flush wins over a new request for this cycle.
        if (flush || flush_pend_q) begin
          valid_d      = '0;
          flush_pend_d = 1'b0;
        end else if (bus.cpu_req) begin
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) hit_cnt_d  = sat_inc(hit_cnt_q);
        else     miss_cnt_d = sat_inc(miss_cnt_q);
        if (we_q) begin
          if (hit) data_d[idx] = wdata_q;
          state_d = S_WR_THRU;
        end else begin
          state_d = hit ? S_IDLE : S_MISS_RD;
        end
      end
      S_MISS_RD: begin
        if (bus.mem_ack) begin
          data_d[idx]  = bus.mem_rdata;
          tag_d[idx]   = tag;
          valid_d[idx] = 1'b1;
          state_d      = S_IDLE;
        end
      end
      S_WR_THRU: begin
        if (bus.mem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && flush) flush_pend_d = 1'b1;
  end

  // Outputs; cpu_ready is masked while reset is asserted so an abort never completes.
  always_comb begin
    busy          = (state_q != S_IDLE);
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.cpu_ready = 1'b0;
    bus.cpu_rdata = '0;
    case (state_q)
      S_LOOKUP: begin
        if (!we_q && hit) begin
          bus.cpu_ready = 1'b1;
          bus.cpu_rdata = data_q[idx];
        end
      end
      S_MISS_RD: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = addr_q;
        if (bus.mem_ack) begin
          bus.cpu_ready = 1'b1;
          bus.cpu_rdata = bus.mem_rdata;
        end
      end
      S_WR_THRU: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        if (bus.mem_ack) bus.cpu_ready = 1'b1;
      end
      default: ;
    endcase
    if (!rst) begin
      bus.cpu_ready = 1'b0;
      bus.cpu_rdata = '0;
    end
  end

  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign dbg_state = state_q;
endmodule
